// File: rtl/ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle core: FSM states, opcodes,
// instruction classes and the extOp/pcSel/wbSel codes seen by the datapath.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_JAL     = 3'd1,
    CL_JALR    = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_LOAD    = 3'd4,
    CL_STORE   = 3'd5,
    CL_ILLEGAL = 3'd6
  } iclass_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_U = 3'd1;
  localparam logic [2:0] EXT_S = 3'd2;
  localparam logic [2:0] EXT_B = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_IMM    = 2'd1;
  localparam logic [1:0] PC_RS1IMM = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller-to-datapath/memory bundle: fetch and data handshakes plus the
// per-state enables. master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic        imemReq;
  logic        imemValid;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [2:0]  extOp;
  logic        aluEn;
  logic        branchTaken;
  logic [1:0]  pcSel;
  logic        pcWe;
  logic        dmemReq;
  logic        dmemWe;
  logic        dmemValid;
  logic        regWe;
  logic [1:0]  wbSel;
  logic        halt;

  modport master (
    output imemReq, instr, extOp, aluEn, pcSel, pcWe,
           dmemReq, dmemWe, regWe, wbSel, halt,
    input  imemValid, imemData, branchTaken, dmemValid
  );

  modport slave (
    input  imemReq, instr, extOp, aluEn, pcSel, pcWe,
           dmemReq, dmemWe, regWe, wbSel, halt,
    output imemValid, imemData, branchTaken, dmemValid
  );
endinterface

// File: rtl/opcode_decoder.sv
// Combinational RV32I opcode classifier: immediate select, instruction class
// and illegal-opcode flag.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_extOp,
  output iclass_e    o_class,
  output logic       o_illegal
);

  always_comb begin
    o_extOp = EXT_I;
    o_class = CL_ILLEGAL;
    case (i_opcode)
      OPC_LUI, OPC_AUIPC: begin o_extOp = EXT_U; o_class = CL_ALU;    end
      OPC_JAL:            begin o_extOp = EXT_J; o_class = CL_JAL;    end
      OPC_JALR:           begin o_extOp = EXT_I; o_class = CL_JALR;   end
      OPC_BRANCH:         begin o_extOp = EXT_B; o_class = CL_BRANCH; end
      OPC_LOAD:           begin o_extOp = EXT_I; o_class = CL_LOAD;   end
      OPC_STORE:          begin o_extOp = EXT_S; o_class = CL_STORE;  end
      OPC_OPIMM, OPC_OP:  begin o_extOp = EXT_I; o_class = CL_ALU;    end
      default: ;
    endcase
    o_illegal = (o_class == CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer (RESET/FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define MULTICYCLE_PERF_EN to add the cycleCnt/retireCnt performance counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [CNT_W-1:0]    cycleCnt,
  output logic [CNT_W-1:0]    retireCnt
`endif
);

  if (RESET_PC_HOLD < 1 || RESET_PC_HOLD > 15 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_ctrl: RESET_PC_HOLD must be 1..15 and CNT_W >= 1");
  end

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_instr;
  logic [2:0]  r_extOp;
  logic [3:0]  r_holdCnt;

  logic [2:0]  w_extOp;
  iclass_e     w_class;
  logic        w_illegal;

  logic        w_imemReq, w_aluEn, w_pcWe, w_dmemReq, w_dmemWe, w_regWe, w_halt;
  logic [1:0]  w_pcSel, w_wbSel;

  opcode_decoder u_dec (
    .i_opcode  (r_instr[6:0]),
    .o_extOp   (w_extOp),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_instr   <= NOP_INSTR;
      r_extOp   <= EXT_I;
      r_holdCnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_RESET && r_holdCnt != HOLD_LAST)
        r_holdCnt <= r_holdCnt + 4'd1;
      if (r_state == ST_FETCH && bus.imemValid)
        r_instr <= bus.imemData;
      if (r_state == ST_DECODE)
        r_extOp <= w_extOp;
    end
  end

  // Stores retire through WB with regWe suppressed, keeping pcWe a Moore strobe.
  always_comb begin
    w_next    = r_state;
    w_imemReq = 1'b0;
    w_aluEn   = 1'b0;
    w_pcWe    = 1'b0;
    w_pcSel   = PC_PLUS4;
    w_dmemReq = 1'b0;
    w_dmemWe  = 1'b0;
    w_regWe   = 1'b0;
    w_wbSel   = WB_ALU;
    w_halt    = 1'b0;
    case (r_state)
      ST_RESET: if (r_holdCnt == HOLD_LAST) w_next = ST_FETCH;
      ST_FETCH: begin
        w_imemReq = 1'b1;
        if (bus.imemValid) w_next = ST_DECODE;
      end
      ST_DECODE: w_next = w_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        w_aluEn = 1'b1;
        case (w_class)
          CL_LOAD, CL_STORE: w_next = ST_MEM;
          CL_BRANCH: begin
            w_pcWe  = 1'b1;
            w_pcSel = bus.branchTaken ? PC_IMM : PC_PLUS4;
            w_next  = ST_FETCH;
          end
          default: w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_dmemReq = 1'b1;
        w_dmemWe  = (w_class == CL_STORE);
        if (bus.dmemValid) w_next = ST_WB;
      end
      ST_WB: begin
        w_regWe = (w_class != CL_STORE) && (r_instr[11:7] != 5'd0);
        w_pcWe  = 1'b1;
        case (w_class)
          CL_LOAD: w_wbSel = WB_LOAD;
          CL_JAL:  begin w_wbSel = WB_PC4; w_pcSel = PC_IMM;    end
          CL_JALR: begin w_wbSel = WB_PC4; w_pcSel = PC_RS1IMM; end
          default: ;
        endcase
        w_next = ST_FETCH;
      end
      ST_TRAP: w_halt = 1'b1;
      default: w_next = ST_RESET;
    endcase
  end

  assign bus.imemReq = w_imemReq;
  assign bus.instr   = r_instr;
  assign bus.extOp   = r_extOp;
  assign bus.aluEn   = w_aluEn;
  assign bus.pcSel   = w_pcSel;
  assign bus.pcWe    = w_pcWe;
  assign bus.dmemReq = w_dmemReq;
  assign bus.dmemWe  = w_dmemWe;
  assign bus.regWe   = w_regWe;
  assign bus.wbSel   = w_wbSel;
  assign bus.halt    = w_halt;

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_W-1:0] r_cycleCnt, r_retireCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycleCnt  <= '0;
      r_retireCnt <= '0;
    end else begin
      if (r_state != ST_RESET && r_state != ST_TRAP)
        r_cycleCnt <= r_cycleCnt + CNT_W'(1);
      if (w_pcWe)
        r_retireCnt <= r_retireCnt + CNT_W'(1);
    end
  end

  assign cycleCnt  = r_cycleCnt;
  assign retireCnt = r_retireCnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle stimulus/expectation
// scoreboard, one task per scenario.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned HOLD = 3;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LUI  = 32'h1234_50B7;
  localparam logic [31:0] SW   = 32'h0011_2223;
  localparam logic [31:0] BEQ  = 32'h0000_0463;
  localparam logic [31:0] JAL  = 32'h0080_00EF;
  localparam logic [31:0] JALR = 32'h0000_80E7;
  localparam logic [31:0] LW0  = 32'h0000_2003;
  localparam logic [31:0] BAD  = 32'h0000_007F;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_ctrl_if bus();
`ifdef MULTICYCLE_PERF_EN
  logic [15:0] cycleCnt, retireCnt;
`endif

  multicycle_ctrl #(.CNT_W(16), .RESET_PC_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycleCnt  (cycleCnt),
    .retireCnt (retireCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imemReq;
    logic       aluEn;
    logic       pcWe;
    logic [1:0] pcSel;
    logic       dmemReq;
    logic       dmemWe;
    logic       regWe;
    logic [1:0] wbSel;
    logic [2:0] extOp;
    logic       halt;
  } exp_t;

  typedef struct packed {
    logic        iv;
    logic [31:0] id;
    logic        bt;
    logic        dv;
    exp_t        e;
  } step_t;

  step_t       sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned steps_since_rst = 0;
  int unsigned retire_exp = 0;

  function automatic exp_t mk(input logic req, input logic alu, input logic pcwe,
                              input logic [1:0] pcsel, input logic dreq, input logic dwe,
                              input logic regwe, input logic [1:0] wbsel,
                              input logic [2:0] ext, input logic hlt);
    return {req, alu, pcwe, pcsel, dreq, dwe, regwe, wbsel, ext, hlt};
  endfunction

  function automatic exp_t idle(input logic [2:0] ext);
    return mk(0, 0, 0, PC_PLUS4, 0, 0, 0, WB_ALU, ext, 0);
  endfunction

  function automatic exp_t fetch(input logic [2:0] ext);
    return mk(1, 0, 0, PC_PLUS4, 0, 0, 0, WB_ALU, ext, 0);
  endfunction

  function automatic exp_t exec(input logic [2:0] ext);
    return mk(0, 1, 0, PC_PLUS4, 0, 0, 0, WB_ALU, ext, 0);
  endfunction

  function automatic exp_t observe();
    return {bus.imemReq, bus.aluEn, bus.pcWe, bus.pcSel, bus.dmemReq, bus.dmemWe,
            bus.regWe, bus.wbSel, bus.extOp, bus.halt};
  endfunction

  task automatic push(input logic iv, input logic [31:0] id, input logic bt,
                      input logic dv, input exp_t e);
    sb.push_back({iv, id, bt, dv, e});
  endtask

  task automatic test_reset();
    exp_t obs;
    rst_n = 1'b1;
    bus.imemValid = 0; bus.imemData = '0; bus.branchTaken = 0; bus.dmemValid = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    obs = observe();
    checks++;
    if (obs !== idle(EXT_I)) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs, idle(EXT_I)); end
    checks++;
    if (bus.instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", bus.instr, NOP); end
`ifdef MULTICYCLE_PERF_EN
    checks++;
    if (cycleCnt !== 16'd0 || retireCnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycleCnt, retireCnt);
    end
`endif
    rst_n = 1'b1;
    for (int unsigned i = 1; i < HOLD; i++) begin
      @(negedge clk); #1;
      obs = observe();
      checks++;
      if (obs !== idle(EXT_I)) begin errors++; $display("FAIL reset_hold%0d got=%h exp=%h", i, obs, idle(EXT_I)); end
    end
    steps_since_rst = 0;
    retire_exp = 0;
  endtask

  task automatic test_alu();
    step_t st; exp_t obs; int unsigned n = 0;
    push(1, ADDI, 0, 0, fetch(EXT_I));
    push(1, $urandom, 0, 0, idle(EXT_I));
    push(1, $urandom, 0, 0, exec(EXT_I));
    push(0, '0, 0, 0, mk(0, 0, 1, PC_PLUS4, 0, 0, 1, WB_ALU, EXT_I, 0));
    push(1, LUI, 0, 0, fetch(EXT_I));
    push(0, '0, 0, 0, idle(EXT_I));
    push(0, '0, 0, 0, exec(EXT_U));
    push(0, '0, 0, 0, mk(0, 0, 1, PC_PLUS4, 0, 0, 1, WB_ALU, EXT_U, 0));
    push(0, '0, 0, 0, fetch(EXT_U));
    while (sb.size() != 0) begin
      @(negedge clk);
      st = sb.pop_front();
      bus.imemValid = st.iv; bus.imemData = st.id; bus.branchTaken = st.bt; bus.dmemValid = st.dv;
      #1 obs = observe();
      checks++; steps_since_rst++; if (st.e.pcWe) retire_exp++;
      if (obs !== st.e) begin errors++; $display("FAIL alu step%0d got=%h exp=%h", n, obs, st.e); end
      n++;
    end
    checks++;
    if (bus.instr !== LUI) begin errors++; $display("FAIL alu_instr got=%h exp=%h", bus.instr, LUI); end
  endtask

  task automatic test_store();
    step_t st; exp_t obs; int unsigned n = 0;
    push(1, SW, 0, 0, fetch(EXT_U));
    push(0, '0, 0, 0, idle(EXT_U));
    push(0, '0, 0, 0, exec(EXT_S));
    for (int unsigned i = 0; i < 4; i++)
      push(1, $urandom, 0, (i == 3), mk(0, 0, 0, PC_PLUS4, 1, 1, 0, WB_ALU, EXT_S, 0));
    push(0, '0, 0, 0, mk(0, 0, 1, PC_PLUS4, 0, 0, 0, WB_ALU, EXT_S, 0));
    push(0, '0, 0, 0, fetch(EXT_S));
    while (sb.size() != 0) begin
      @(negedge clk);
      st = sb.pop_front();
      bus.imemValid = st.iv; bus.imemData = st.id; bus.branchTaken = st.bt; bus.dmemValid = st.dv;
      #1 obs = observe();
      checks++; steps_since_rst++; if (st.e.pcWe) retire_exp++;
      if (obs !== st.e) begin errors++; $display("FAIL store step%0d got=%h exp=%h", n, obs, st.e); end
      n++;
    end
    checks++;
    if (bus.instr !== SW) begin errors++; $display("FAIL store_instr got=%h exp=%h", bus.instr, SW); end
  endtask

  task automatic test_branch();
    step_t st; exp_t obs; int unsigned n = 0;
    push(1, BEQ, 0, 0, fetch(EXT_S));
    push(0, '0, 0, 0, idle(EXT_S));
    push(0, '0, 1, 0, mk(0, 1, 1, PC_IMM, 0, 0, 0, WB_ALU, EXT_B, 0));
    push(1, BEQ, 1, 0, fetch(EXT_B));
    push(0, '0, 1, 0, idle(EXT_B));
    push(0, '0, 0, 0, mk(0, 1, 1, PC_PLUS4, 0, 0, 0, WB_ALU, EXT_B, 0));
    push(0, '0, 1, 0, fetch(EXT_B));
    while (sb.size() != 0) begin
      @(negedge clk);
      st = sb.pop_front();
      bus.imemValid = st.iv; bus.imemData = st.id; bus.branchTaken = st.bt; bus.dmemValid = st.dv;
      #1 obs = observe();
      checks++; steps_since_rst++; if (st.e.pcWe) retire_exp++;
      if (obs !== st.e) begin errors++; $display("FAIL branch step%0d got=%h exp=%h", n, obs, st.e); end
      n++;
    end
  endtask

  task automatic test_trap();
    step_t st; exp_t obs; int unsigned n = 0;
    push(1, BAD, 0, 0, fetch(EXT_B));
    push(0, '0, 0, 0, idle(EXT_B));
    for (int unsigned i = 0; i < 20; i++)
      push(1'($urandom_range(0, 1)), $urandom, 1, 1, mk(0, 0, 0, PC_PLUS4, 0, 0, 0, WB_ALU, EXT_I, 1));
    while (sb.size() != 0) begin
      @(negedge clk);
      st = sb.pop_front();
      bus.imemValid = st.iv; bus.imemData = st.id; bus.branchTaken = st.bt; bus.dmemValid = st.dv;
      #1 obs = observe();
      checks++; steps_since_rst++; if (st.e.pcWe) retire_exp++;
      if (obs !== st.e) begin errors++; $display("FAIL trap step%0d got=%h exp=%h", n, obs, st.e); end
      n++;
    end
    @(negedge clk);
    bus.imemValid = 0; bus.branchTaken = 0; bus.dmemValid = 0;
    rst_n = 1'b0;
    #1 obs = observe();
    checks++;
    if (obs !== idle(EXT_I)) begin errors++; $display("FAIL trap_clear got=%h exp=%h", obs, idle(EXT_I)); end
    checks++;
    if (bus.instr !== NOP) begin errors++; $display("FAIL trap_instr got=%h exp=%h", bus.instr, NOP); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 1; i < HOLD; i++) begin
      @(negedge clk); #1;
      obs = observe();
      checks++;
      if (obs !== idle(EXT_I)) begin errors++; $display("FAIL trap_hold%0d got=%h exp=%h", i, obs, idle(EXT_I)); end
    end
    steps_since_rst = 0;
    retire_exp = 0;
  endtask

  task automatic test_jump_load();
    step_t st; exp_t obs; int unsigned n = 0;
    push(1, JAL, 0, 0, fetch(EXT_I));
    push(0, '0, 0, 0, idle(EXT_I));
    push(0, '0, 0, 0, exec(EXT_J));
    push(0, '0, 0, 0, mk(0, 0, 1, PC_IMM, 0, 0, 1, WB_PC4, EXT_J, 0));
    push(1, JALR, 0, 0, fetch(EXT_J));
    push(0, '0, 0, 0, idle(EXT_J));
    push(0, '0, 0, 0, exec(EXT_I));
    push(0, '0, 0, 0, mk(0, 0, 1, PC_RS1IMM, 0, 0, 1, WB_PC4, EXT_I, 0));
    push(1, LW0, 0, 0, fetch(EXT_I));
    push(0, '0, 0, 0, idle(EXT_I));
    push(0, '0, 0, 0, exec(EXT_I));
    push(0, '0, 0, 1, mk(0, 0, 0, PC_PLUS4, 1, 0, 0, WB_ALU, EXT_I, 0));
    push(0, '0, 0, 0, mk(0, 0, 1, PC_PLUS4, 0, 0, 0, WB_LOAD, EXT_I, 0));
    push(0, '0, 0, 0, fetch(EXT_I));
    while (sb.size() != 0) begin
      @(negedge clk);
      st = sb.pop_front();
      bus.imemValid = st.iv; bus.imemData = st.id; bus.branchTaken = st.bt; bus.dmemValid = st.dv;
      #1 obs = observe();
      checks++; steps_since_rst++; if (st.e.pcWe) retire_exp++;
      if (obs !== st.e) begin errors++; $display("FAIL jump_load step%0d got=%h exp=%h", n, obs, st.e); end
      n++;
    end
  endtask

  task automatic test_reset_midfetch();
    exp_t obs;
    @(negedge clk);
    bus.imemValid = 1; bus.imemData = ADDI;
    #1;
    checks++;
    if (bus.imemReq !== 1'b1) begin errors++; $display("FAIL midfetch_req got=%b exp=1", bus.imemReq); end
`ifdef MULTICYCLE_PERF_EN
    checks++;
    if (cycleCnt !== 16'(steps_since_rst) || retireCnt !== 16'(retire_exp)) begin
      errors++;
      $display("FAIL perf_counts got=%0d/%0d exp=%0d/%0d", cycleCnt, retireCnt, steps_since_rst, retire_exp);
    end
`endif
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imemReq !== 1'b0) begin errors++; $display("FAIL midfetch_drop got=%b exp=0", bus.imemReq); end
    @(negedge clk); #1;
    obs = observe();
    checks++;
    if (obs !== idle(EXT_I)) begin errors++; $display("FAIL midfetch_quiet got=%h exp=%h", obs, idle(EXT_I)); end
    checks++;
    if (bus.instr !== NOP) begin errors++; $display("FAIL midfetch_instr got=%h exp=%h", bus.instr, NOP); end
`ifdef MULTICYCLE_PERF_EN
    checks++;
    if (cycleCnt !== 16'd0 || retireCnt !== 16'd0) begin
      errors++; $display("FAIL midfetch_counters got=%0d/%0d exp=0/0", cycleCnt, retireCnt);
    end
`endif
    bus.imemValid = 0;
    rst_n = 1'b1;
    for (int unsigned i = 1; i < HOLD; i++) @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (bus.imemReq !== 1'b1) begin errors++; $display("FAIL midfetch_refetch got=%b exp=1", bus.imemReq); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_branch();
    test_trap();
    test_jump_load();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
